// File: rtl/pal_raster_gen_if.sv
// Framebuffer fetch handshake: pal_raster_gen is the master, the fetch unit the slave.
// A transfer happens on any clkvideo cycle where pix_req and pix_ack are both high.
interface pal_raster_gen_if;
    logic       pix_req;
    logic       pix_ack;
    logic [8:0] pix_data;   // {r[2:0], g[2:0], b[2:0]}

    modport master (output pix_req, input pix_ack, input pix_data);
    modport slave  (input pix_req, output pix_ack, output pix_data);
endinterface

// File: rtl/pal_raster_gen.sv
// 15 kHz PAL raster generator: h/v counters, 4-entry pixel prefetch FIFO, registered syncs and 3:3:3 RGB.
// Optional: define PAL_RASTER_BORDER_EN to add a border_color input shown outside the active window.
module pal_raster_gen #(
    parameter int H_TOTAL     = 448,
    parameter int H_SYNC_LEN  = 32,
    parameter int H_ACT_START = 96,
    parameter int H_ACTIVE    = 320,
    parameter int V_TOTAL     = 312,
    parameter int V_SYNC_LEN  = 3,
    parameter int V_ACT_START = 40,
    parameter int V_ACTIVE    = 256
) (
    input  logic             clkvideo,
    input  logic             rst,
    input  logic             ce,
    pal_raster_gen_if.master pix,
`ifdef PAL_RASTER_BORDER_EN
    input  logic [8:0]       border_color,
`endif
    output logic [2:0]       ro,
    output logic [2:0]       go,
    output logic [2:0]       bo,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync_n,
    output logic             blank,
    output logic [8:0]       hcount,
    output logic [8:0]       vcount,
    output logic             underflow
);

    localparam int         FIFO_DEPTH = 4;
    localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_SYNC_END = 9'(H_SYNC_LEN);
    localparam logic [8:0] V_SYNC_END = 9'(V_SYNC_LEN);
    localparam logic [8:0] H_ACT_BEG  = 9'(H_ACT_START);
    localparam logic [8:0] H_ACT_END  = 9'(H_ACT_START + H_ACTIVE);
    localparam logic [8:0] V_ACT_BEG  = 9'(V_ACT_START);
    localparam logic [8:0] V_ACT_END  = 9'(V_ACT_START + V_ACTIVE);
    localparam logic [8:0] FETCH_MAX  = 9'(H_ACTIVE);
    localparam logic [2:0] FIFO_FULL  = 3'(FIFO_DEPTH);

    logic [8:0] h;
    logic [8:0] v;
    logic       line_active;
    logic       pix_active;
    logic       hsync_on;
    logic       vsync_on;
    logic       line_start;

    logic [8:0] fetch_cnt;
    logic [8:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic [8:0] pix_next;

    assign line_active = (v >= V_ACT_BEG) && (v < V_ACT_END);
    assign pix_active  = line_active && (h >= H_ACT_BEG) && (h < H_ACT_END);
    assign hsync_on    = h < H_SYNC_END;
    assign vsync_on    = v < V_SYNC_END;
    assign line_start  = ce && (h == 9'd0);

    assign fifo_full  = fifo_cnt == FIFO_FULL;
    assign fifo_empty = fifo_cnt == 3'd0;

    // Requests run at the full video clock so the FIFO refills between slow pixel enables.
    assign pix.pix_req = line_active && (fetch_cnt < FETCH_MAX) && !fifo_full;

    // The line-start flush wins over a same-cycle transfer, which is then lost.
    assign push = pix.pix_req && pix.pix_ack && !line_start;
    assign pop  = ce && pix_active && !fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge counter values; that is what keeps syncs, colour and hcount/vcount aligned.
    always_ff @(posedge clkvideo) begin
        if (rst) begin
            h <= 9'd0;
            v <= 9'd0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= 9'd0;
                v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
            end else begin
                h <= h + 9'd1;
            end
        end
    end

    always_ff @(posedge clkvideo) begin
        if (rst || line_start) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            fifo_cnt  <= 3'd0;
            fetch_cnt <= 9'd0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 2'd1;
                fetch_cnt <= fetch_cnt + 9'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; pointers and count alone say which
    // entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clkvideo) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pix.pix_data;
        end
    end

    // NOTE: pix_next gets a default before any branch so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pix_next = 9'h000;
        if (pix_active) begin
            if (!fifo_empty) begin
                pix_next = fifo_mem[rd_ptr];
            end
        end
`ifdef PAL_RASTER_BORDER_EN
        else if (!hsync_on && !vsync_on) begin
            pix_next = border_color;
        end
`endif
    end

    always_ff @(posedge clkvideo) begin
        if (rst) begin
            ro        <= 3'd0;
            go        <= 3'd0;
            bo        <= 3'd0;
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
            csync_n   <= 1'b1;
            blank     <= 1'b1;
            hcount    <= 9'd0;
            vcount    <= 9'd0;
            underflow <= 1'b0;
        end else if (ce) begin
            {ro, go, bo} <= pix_next;
            hsync_n      <= !hsync_on;
            vsync_n      <= !vsync_on;
            // Serrated composite sync: inverted hsync inside the vsync lines.
            csync_n      <= !(hsync_on ^ vsync_on);
            blank        <= !pix_active;
            hcount       <= h;
            vcount       <= v;
            if (pix_active && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pal_raster_gen.sv
// Directed bench for pal_raster_gen: a full-size instance plus a short-frame instance for the vertical wrap.
// Honours PAL_RASTER_BORDER_EN the same way as the design.
module tb_pal_raster_gen;

    localparam int HT = 448;
`ifdef PAL_RASTER_BORDER_EN
    localparam logic [8:0] BORDER = 9'h1C0;
`else
    localparam logic [8:0] BORDER = 9'h000;
`endif

    logic clkvideo = 1'b0;
    logic rst      = 1'b1;
    logic ce       = 1'b1;
    logic ack_en   = 1'b1;
    always #5 clkvideo = ~clkvideo;

    pal_raster_gen_if fb ();
    pal_raster_gen_if fb_s ();

    logic [2:0] ro, go, bo, ro_s, go_s, bo_s;
    logic       hsync_n, vsync_n, csync_n, blank, underflow;
    logic       hsync_n_s, vsync_n_s, csync_n_s, blank_s, underflow_s;
    logic [8:0] hcount, vcount, hcount_s, vcount_s;
`ifdef PAL_RASTER_BORDER_EN
    logic [8:0] border_color = 9'h1C0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side raster position (internal counter state after the latest edge) and fetch unit.
    int         mh        = 0;
    int         mv        = 0;
    logic [8:0] fetch_idx = 9'd0;
    int         early_req = 0;

    assign fb.pix_ack    = ack_en;
    assign fb.pix_data   = fetch_idx;
    assign fb_s.pix_ack  = 1'b1;
    assign fb_s.pix_data = 9'h0AA;

    always @(posedge clkvideo) begin
        if (rst) begin
            mh        <= 0;
            mv        <= 0;
            fetch_idx <= 9'd0;
        end else begin
            if (ce && mh == 0)
                fetch_idx <= 9'd0;
            else if (fb.pix_req && fb.pix_ack)
                fetch_idx <= fetch_idx + 9'd1;
            if (ce) begin
                if (mh == HT - 1) begin
                    mh <= 0;
                    mv <= (mv == 311) ? 0 : mv + 1;
                end else begin
                    mh <= mh + 1;
                end
            end
        end
    end

    always @(negedge clkvideo) begin
        if (rst === 1'b0 && fb.pix_req !== 1'b0 && mv < 40)
            early_req <= early_req + 1;
    end

    pal_raster_gen dut (
        .clkvideo(clkvideo), .rst(rst), .ce(ce), .pix(fb),
`ifdef PAL_RASTER_BORDER_EN
        .border_color(border_color),
`endif
        .ro(ro), .go(go), .bo(bo),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n), .blank(blank),
        .hcount(hcount), .vcount(vcount), .underflow(underflow)
    );

    pal_raster_gen #(.V_TOTAL(8), .V_SYNC_LEN(3), .V_ACT_START(4), .V_ACTIVE(2)) dut_s (
        .clkvideo(clkvideo), .rst(rst), .ce(ce), .pix(fb_s),
`ifdef PAL_RASTER_BORDER_EN
        .border_color(border_color),
`endif
        .ro(ro_s), .go(go_s), .bo(bo_s),
        .hsync_n(hsync_n_s), .vsync_n(vsync_n_s), .csync_n(csync_n_s), .blank(blank_s),
        .hcount(hcount_s), .vcount(vcount_s), .underflow(underflow_s)
    );

    function automatic logic [8:0] exp_border(input int h, input int v);
        return (h < 32 || v < 3) ? 9'h000 : BORDER;
    endfunction

    task automatic step();
        @(posedge clkvideo);
        #1;
    endtask

    // Step until the next ce edge will process raster position (v, h).
    task automatic wait_at(input int v, input int h);
        int guard;
        guard = 0;
        while (!(mv == v && mh == h)) begin
            step();
            guard++;
            if (guard > 150000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_at: position v=%0d h=%0d not reached, stuck at v=%0d h=%0d", v, h, mv, mh);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (hcount !== 9'd0 || vcount !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_counts: hcount=%0d vcount=%0d, required 0/0", hcount, vcount);
        end
        n_cmp++;
        if ({hsync_n, vsync_n, csync_n, blank, underflow, fb.pix_req} !== 6'b111100) begin
            n_bad++;
            $display("FAIL reset_flags: hs/vs/cs/blank/uf/req=%b, required 111100",
                     {hsync_n, vsync_n, csync_n, blank, underflow, fb.pix_req});
        end
        n_cmp++;
        if ({ro, go, bo} !== 9'h000 || {vsync_n_s, fb_s.pix_req} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_rgb: rgb=%h small vs/req=%b, required 000 and 10",
                     {ro, go, bo}, {vsync_n_s, fb_s.pix_req});
        end
        rst = 1'b0;
    endtask

    // Nine lines from reset: sync widths, csync serration, blanking, border, short-frame wrap.
    task automatic test_sync();
        int hs_low, vs_low, e_hs, e_cs, e_hc, e_rgb, e_small, req_s_bad, req_s_on;
        int h, v;
        hs_low = 0; vs_low = 0; e_hs = 0; e_cs = 0; e_hc = 0; e_rgb = 0;
        e_small = 0; req_s_bad = 0; req_s_on = 0;
        for (int k = 0; k < 9 * HT; k++) begin
            h = k % HT;
            v = k / HT;
            step();
            if (hsync_n === 1'b0) hs_low++;
            if (vsync_n === 1'b0) vs_low++;
            if (hsync_n !== (h >= 32) || vsync_n !== (v >= 3)) e_hs++;
            if (csync_n !== ~((h < 32) ^ (v < 3))) e_cs++;
            if (hcount !== 9'(h) || vcount !== 9'(v)) e_hc++;
            if ({ro, go, bo} !== exp_border(h, v) || blank !== 1'b1) e_rgb++;
            if (hcount_s !== 9'(h) || vcount_s !== 9'(v % 8) || vsync_n_s !== ((v % 8) >= 3)) e_small++;
            if (fb_s.pix_req !== 1'b0 && !((mv % 8) == 4 || (mv % 8) == 5)) req_s_bad++;
            if (fb_s.pix_req === 1'b1) req_s_on++;
        end
        n_cmp++;
        if (hs_low !== 9 * 32) begin
            n_bad++;
            $display("FAIL hsync_width: %0d low cycles, required %0d", hs_low, 9 * 32);
        end
        n_cmp++;
        if (vs_low !== 3 * HT) begin
            n_bad++;
            $display("FAIL vsync_width: %0d low cycles, required %0d", vs_low, 3 * HT);
        end
        n_cmp++;
        if (e_hs !== 0 || e_cs !== 0) begin
            n_bad++;
            $display("FAIL sync_position: %0d hs/vs and %0d csync mismatching cycles, required 0", e_hs, e_cs);
        end
        n_cmp++;
        if (e_hc !== 0 || e_rgb !== 0) begin
            n_bad++;
            $display("FAIL blank_border: %0d count and %0d colour/blank mismatching cycles, required 0", e_hc, e_rgb);
        end
        n_cmp++;
        if (e_small !== 0 || req_s_bad !== 0 || req_s_on == 0) begin
            n_bad++;
            $display("FAIL short_frame_wrap: %0d count errs, %0d stray req, %0d req cycles, required 0/0/>0",
                     e_small, req_s_bad, req_s_on);
        end
    endtask

    task automatic test_active();
        int e_rgb, e_blank;
        logic [8:0] exp;
        e_rgb = 0; e_blank = 0;
        wait_at(40, 0);
        for (int j = 0; j < HT; j++) begin
            step();
            exp = (j >= 96 && j < 416) ? 9'(j - 96) : exp_border(j, 40);
            if ({ro, go, bo} !== exp || hcount !== 9'(j) || vcount !== 9'd40) e_rgb++;
            if (blank !== !(j >= 96 && j < 416)) e_blank++;
            if (j == 10 || j == 50 || j == 96 || j == 415) begin
                n_cmp++;
                if ({ro, go, bo} !== exp) begin
                    n_bad++;
                    $display("FAIL line40_col%0d: rgb=%h, required %h", j, {ro, go, bo}, exp);
                end
            end
        end
        n_cmp++;
        if (e_rgb !== 0 || e_blank !== 0) begin
            n_bad++;
            $display("FAIL line40_scan: %0d colour and %0d blank mismatches, required 0", e_rgb, e_blank);
        end
        n_cmp++;
        if (fetch_idx !== 9'd320) begin
            n_bad++;
            $display("FAIL line40_transfers: %0d, required 320", fetch_idx);
        end
        n_cmp++;
        if (early_req !== 0 || underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL top_border_req: %0d req cycles on lines 0..39, underflow=%b, required 0/0",
                     early_req, underflow);
        end
    endtask

    task automatic test_underflow();
        int e_zero, e_51;
        e_zero = 0; e_51 = 0;
        wait_at(50, 0);
        for (int j = 0; j < HT; j++) begin
            ack_en = (j >= 100);
            step();
            if (j >= 96 && j <= 100 && {ro, go, bo} !== 9'h000) e_zero++;
            if (j == 95) begin
                n_cmp++;
                if (underflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL underflow_early: underflow=%b at h=95, required 0", underflow);
                end
            end
            if (j == 96) begin
                n_cmp++;
                if (underflow !== 1'b1) begin
                    n_bad++;
                    $display("FAIL underflow_set: underflow=%b at h=96, required 1", underflow);
                end
            end
            if (j == 110 || j == 415) begin
                n_cmp++;
                if ({ro, go, bo} !== 9'(j - 101)) begin
                    n_bad++;
                    $display("FAIL no_replay_col%0d: rgb=%h, required %h", j, {ro, go, bo}, 9'(j - 101));
                end
            end
        end
        n_cmp++;
        if (e_zero !== 0) begin
            n_bad++;
            $display("FAIL starved_pixels: %0d nonzero among h=96..100, required 0", e_zero);
        end
        ack_en = 1'b1;
        for (int j = 0; j < HT; j++) begin
            step();
            if (j >= 96 && j < 416 && {ro, go, bo} !== 9'(j - 96)) e_51++;
        end
        n_cmp++;
        if (e_51 !== 0 || underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL line51_flush: %0d colour mismatches, underflow=%b, required 0/1", e_51, underflow);
        end
    endtask

    task automatic test_ce_quarter();
        int occ_bad, req_bad, hold_bad, rgb_bad, full_seen, pops, occ;
        logic exp_req;
        logic [8:0] exp;
        occ_bad = 0; req_bad = 0; hold_bad = 0; rgb_bad = 0; full_seen = 0;
        wait_at(52, 0);
        for (int j = 0; j < HT; j++) begin
            exp = (j >= 96 && j < 416) ? 9'(j - 96) : exp_border(j, 52);
            for (int p = 0; p < 4; p++) begin
                ce = (p == 0);
                step();
                pops = (j < 96) ? 0 : ((j < 416) ? j - 95 : 320);
                occ  = int'(fetch_idx) - pops;
                if (occ > 4 || occ < 0) occ_bad++;
                if (occ == 4) full_seen++;
                exp_req = (fetch_idx < 9'd320) && (occ < 4);
                if (fb.pix_req !== exp_req) req_bad++;
                if (hcount !== 9'(j) || vcount !== 9'd52) hold_bad++;
                if ({ro, go, bo} !== exp) rgb_bad++;
            end
        end
        ce = 1'b1;
        n_cmp++;
        if (occ_bad !== 0 || full_seen == 0) begin
            n_bad++;
            $display("FAIL ce4_occupancy: %0d out-of-range cycles, %0d full cycles, required 0/>0", occ_bad, full_seen);
        end
        n_cmp++;
        if (req_bad !== 0) begin
            n_bad++;
            $display("FAIL ce4_req: %0d cycles with wrong pix_req, required 0", req_bad);
        end
        n_cmp++;
        if (hold_bad !== 0 || rgb_bad !== 0) begin
            n_bad++;
            $display("FAIL ce4_hold: %0d count and %0d colour mismatches, required 0", hold_bad, rgb_bad);
        end
    endtask

    task automatic test_reset_mid();
        wait_at(100, 200);
        n_cmp++;
        if (fb.pix_req !== 1'b1) begin
            n_bad++;
            $display("FAIL pending_req: pix_req=%b at v=100 h=200, required 1", fb.pix_req);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({hsync_n, vsync_n, csync_n, blank, underflow, fb.pix_req} !== 6'b111100 ||
            {ro, go, bo} !== 9'h000 || hcount !== 9'd0 || vcount !== 9'd0) begin
            n_bad++;
            $display("FAIL midline_reset: flags=%b rgb=%h h=%0d v=%0d, required 111100/000/0/0",
                     {hsync_n, vsync_n, csync_n, blank, underflow, fb.pix_req}, {ro, go, bo}, hcount, vcount);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (hcount !== 9'd0 || vcount !== 9'd0 || {hsync_n, vsync_n} !== 2'b00) begin
            n_bad++;
            $display("FAIL restart_first: h=%0d v=%0d hs/vs=%b, required 0/0/00",
                     hcount, vcount, {hsync_n, vsync_n});
        end
        step();
        n_cmp++;
        if (hcount !== 9'd1 || vcount !== 9'd0 || fb.pix_req !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_second: h=%0d v=%0d req=%b, required 1/0/0", hcount, vcount, fb.pix_req);
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_active();
        test_underflow();
        test_ce_quarter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
